// File: rtl/mem_alu_engine_pkg.sv
// Shared types and constants for the memory-to-ALU vector engine.
// Imported by the engine, its address generator and the bus interface users.
package mem_alu_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 12;
   localparam int DEF_OP_W   = 4;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      EXEC,
      WR,
      FIN
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;

endpackage

// File: rtl/mem_alu_engine_if.sv
// Memory and ALU bus seen by the engine.
// master = engine side, slave = memory/ALU side.
interface mem_alu_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12,
   parameter int OP_W   = 4
);

   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   modport master (
      output mem_we, mem_re, mem_addr, mem_wdata,
      output alu_a, alu_b, alu_op,
      input  mem_rdata, alu_result, alu_carry
   );

   modport slave (
      input  mem_we, mem_re, mem_addr, mem_wdata,
      input  alu_a, alu_b, alu_op,
      output mem_rdata, alu_result, alu_carry
   );

endinterface

// File: rtl/mem_alu_addr_gen.sv
// Latched region bases and element index for one job.
// Produces the three element addresses and the last-element flag.
module mem_alu_addr_gen
   import mem_alu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  count,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic [ADDR_W-1:0] addr_d,
   output logic              last
);

   logic [ADDR_W-1:0] base_a;
   logic [ADDR_W-1:0] base_b;
   logic [ADDR_W-1:0] base_d;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W:0]    idx_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         base_a <= '0;
         base_b <= '0;
         base_d <= '0;
         len    <= '0;
         idx    <= '0;
      end else if (load) begin
         base_a <= src_a;
         base_b <= src_b;
         base_d <= dst;
         len    <= count;
         idx    <= '0;
      end else if (inc) begin
         idx    <= idx + 1'b1;
      end
   end

   // Addresses wrap naturally at the top of memory.
   assign addr_a = base_a + ADDR_W'(idx);
   assign addr_b = base_b + ADDR_W'(idx);
   assign addr_d = base_d + ADDR_W'(idx);

   // One extra bit so count = 2^LEN_W-1 compares cleanly.
   assign idx_nx = {1'b0, idx} + {{LEN_W{1'b0}}, 1'b1};
   assign last   = (idx_nx == {1'b0, len});

endmodule

// File: rtl/mem_alu_engine.sv
// Vector engine: reads A/B operand pairs, runs them through the ALU,
// writes results to the destination region, four cycles per element.
module mem_alu_engine
   import mem_alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int OP_W   = DEF_OP_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   opcode,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              carry_any,
   mem_alu_engine_if.master  bus
);

   state_t            state;
   state_t            nxt;
   logic [OP_W-1:0]   op_q;
   logic [OP_W-1:0]   alu_op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              carry_q;
   logic              done_q;
   logic              load;
   logic              inc;
   logic              last;
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [ADDR_W-1:0] addr_d;

   mem_alu_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .inc    (inc),
      .src_a  (src_a),
      .src_b  (src_b),
      .dst    (dst),
      .count  (count),
      .addr_a (addr_a),
      .addr_b (addr_b),
      .addr_d (addr_d),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         alu_op_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state  <= nxt;
         done_q <= (state == FIN);
         if (load) begin
            op_q    <= opcode;
            carry_q <= 1'b0;
         end
         if (state == RD_B) a_q <= bus.mem_rdata;
         if (state == EXEC) begin
            b_q      <= bus.mem_rdata;
            alu_op_q <= op_q;
         end
         if (state == WR) carry_q <= carry_q | bus.alu_carry;
      end
   end

   always_comb begin
      nxt   = state;
      load  = 1'b0;
      inc   = 1'b0;
      we    = 1'b0;
      re    = 1'b0;
      addr  = '0;
      wdata = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               nxt  = (count == '0) ? FIN : RD_A;
            end
         end
         RD_A: begin
            re   = 1'b1;
            addr = addr_a;
            nxt  = RD_B;
         end
         RD_B: begin
            re   = 1'b1;
            addr = addr_b;
            nxt  = EXEC;
         end
         EXEC: nxt = WR;
         WR: begin
            we    = 1'b1;
            addr  = addr_d;
            wdata = bus.alu_result;
            inc   = 1'b1;
            nxt   = last ? FIN : RD_A;
         end
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // A reset landing on a write cycle must not commit that write.
      if (reset) begin
         we = 1'b0;
         re = 1'b0;
      end
   end

   assign bus.mem_we    = we;
   assign bus.mem_re    = re;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = wdata;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_op    = alu_op_q;

   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign carry_any = carry_q;

endmodule

// File: tb/tb_mem_alu_engine.sv
// Randomised bench for mem_alu_engine with a job-level reference model.
// Memory and ALU are modelled here; every bus cycle is checked against the model.
module tb_mem_alu_engine;
   import mem_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  opcode = '0;
   logic [11:0] src_a = '0;
   logic [11:0] src_b = '0;
   logic [11:0] dst = '0;
   logic [7:0]  count = '0;
   logic        busy;
   logic        done;
   logic        carry_any;

   mem_alu_engine_if bus ();

   mem_alu_engine dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .opcode    (opcode),
      .src_a     (src_a),
      .src_b     (src_b),
      .dst       (dst),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .carry_any (carry_any),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  dut_mem [4096];
   logic [7:0]  ref_mem [4096];
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;
   logic [11:0] exp_rd [$];
   logic [19:0] exp_wr [$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [8:0] alu9(input logic [3:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
      case (op)
         ALU_ADD: return {1'b0, a} + {1'b0, b};
         ALU_SUB: return {1'b0, a} - {1'b0, b};
         ALU_AND: return {1'b0, a & b};
         ALU_OR:  return {1'b0, a | b};
         ALU_XOR: return {1'b0, a ^ b};
         default: return 9'd0;
      endcase
   endfunction

   always_comb {bus.alu_carry, bus.alu_result} = alu9(bus.alu_op, bus.alu_a, bus.alu_b);

   always @(posedge clk) begin
      if (pl_en) dut_mem[pl_addr] <= pl_data;
      else if (bus.mem_we) dut_mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= dut_mem[bus.mem_addr];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle bus compare against the expected access streams.
   task automatic mon_cycle();
      logic [11:0] ea;
      logic [19:0] ew;
      if (reset) return;
      chk("we_re_excl", longint'(bus.mem_we & bus.mem_re), 0);
      if (bus.mem_re) begin
         chk("rd_expected", longint'(exp_rd.size() > 0), 1);
         if (exp_rd.size() > 0) begin
            ea = exp_rd.pop_front();
            chk("rd_addr", bus.mem_addr, ea);
         end
      end
      if (bus.mem_we) begin
         chk("wr_expected", longint'(exp_wr.size() > 0), 1);
         if (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            chk("wr_addr", bus.mem_addr, ew[19:8]);
            chk("wr_data", bus.mem_wdata, ew[7:0]);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon_cycle();
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_mem[a] = d;
      tick();
      pl_en = 1'b0;
   endtask

   // Sequential element semantics: reads of element i see all earlier writes.
   task automatic model_job(input logic [3:0] op, input logic [11:0] sa,
                            input logic [11:0] sb, input logic [11:0] d,
                            input int n, input int napply, output bit cy);
      cy = 1'b0;
      for (int i = 0; i < n; i++) begin
         logic [11:0] aa;
         logic [11:0] bb;
         logic [11:0] dd;
         logic [8:0]  r;
         aa = sa + 12'(i);
         bb = sb + 12'(i);
         dd = d + 12'(i);
         r  = alu9(op, ref_mem[aa], ref_mem[bb]);
         exp_rd.push_back(aa);
         exp_rd.push_back(bb);
         exp_wr.push_back({dd, r[7:0]});
         cy = cy | r[8];
         if (i < napply) ref_mem[dd] = r[7:0];
      end
   endtask

   task automatic cmp_mem(input string name);
      int bad = 0;
      for (int i = 0; i < 4096; i++)
         if (dut_mem[i] !== ref_mem[i]) bad++;
      chk(name, bad, 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_carry", carry_any, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_re", bus.mem_re, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_op", bus.alu_op, 0);
   endtask

   task automatic run_job(input logic [3:0] op, input logic [11:0] sa,
                          input logic [11:0] sb, input logic [11:0] d,
                          input int n, input bit intrude);
      bit exp_c;
      int got = -1;
      int busy_low = 0;
      model_job(op, sa, sb, d, n, n, exp_c);
      opcode = op;
      src_a  = sa;
      src_b  = sb;
      dst    = d;
      count  = 8'(n);
      start  = 1'b1;
      for (int k = 1; k <= 4 * n + 40; k++) begin
         tick();
         if (k == 1) begin
            start = 1'b0;
            chk("carry_clr", carry_any, 0);
         end
         if (intrude && k == 5) begin
            start  = 1'b1;
            opcode = ALU_XOR;
            src_a  = 12'($urandom);
            src_b  = 12'($urandom);
            dst    = 12'($urandom);
            count  = 8'd2;
         end
         if (intrude && k == 6) start = 1'b0;
         if (done) begin
            got = k;
            break;
         end
         if (!busy) busy_low++;
      end
      chk("done_latency", got, 4 * n + 2);
      chk("busy_during_job", busy_low, 0);
      chk("busy_at_done", busy, 0);
      chk("carry_any", carry_any, exp_c);
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      exp_rd.delete();
      exp_wr.delete();
      cmp_mem("mem_image");
   endtask

   initial begin
      bit cy;
      int done_seen;
      // start together with reset must be ignored
      reset = 1'b1;
      start = 1'b1;
      count = 8'd3;
      repeat (3) tick();
      check_reset_vals();
      start = 1'b0;
      reset = 1'b0;
      tick();
      chk("reset_wins_busy", busy, 0);

      for (int a = 0; a < 4096; a++) poke(12'(a), 8'($urandom));

      // Test 1: basic add
      for (int i = 0; i < 4; i++) begin
         poke(12'h010 + 12'(i), 8'(i + 1));
         poke(12'h020 + 12'(i), 8'(10 * (i + 1)));
      end
      run_job(ALU_ADD, 12'h010, 12'h020, 12'h030, 4, 1'b0);
      chk("t1_r0", dut_mem[12'h030], 11);
      chk("t1_r1", dut_mem[12'h031], 22);
      chk("t1_r2", dut_mem[12'h032], 33);
      chk("t1_r3", dut_mem[12'h033], 44);
      chk("t1_carry", carry_any, 0);

      // Test 2: carry set, then cleared by the next job
      poke(12'h200, 8'hFF);
      poke(12'h210, 8'h01);
      run_job(ALU_ADD, 12'h200, 12'h210, 12'h220, 1, 1'b0);
      chk("t2_res", dut_mem[12'h220], 0);
      chk("t2_carry", carry_any, 1);
      poke(12'h201, 8'h01);
      poke(12'h211, 8'h01);
      run_job(ALU_ADD, 12'h201, 12'h211, 12'h221, 1, 1'b0);
      chk("t2b_res", dut_mem[12'h221], 2);
      chk("t2b_carry", carry_any, 0);

      // Test 3: empty job
      run_job(ALU_SUB, 12'h300, 12'h310, 12'h320, 0, 1'b0);

      // Test 4: wrap with in-place overlap
      poke(12'hFFE, 8'd1);
      poke(12'hFFF, 8'd2);
      poke(12'h000, 8'd3);
      poke(12'h100, 8'd10);
      poke(12'h101, 8'd20);
      poke(12'h102, 8'd30);
      run_job(ALU_ADD, 12'hFFE, 12'h100, 12'hFFF, 3, 1'b0);
      chk("t4_fff", dut_mem[12'hFFF], 11);
      chk("t4_000", dut_mem[12'h000], 31);
      chk("t4_001", dut_mem[12'h001], 61);

      // Test 5: start while busy is ignored
      run_job(ALU_SUB, 12'h400, 12'h410, 12'h420, 4, 1'b1);

      // Test 6: reset during the write of element 2
      model_job(ALU_ADD, 12'h500, 12'h510, 12'h520, 4, 2, cy);
      opcode = ALU_ADD;
      src_a  = 12'h500;
      src_b  = 12'h510;
      dst    = 12'h520;
      count  = 8'd4;
      start  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) start = 1'b0;
      end
      reset = 1'b1;
      tick();
      check_reset_vals();
      reset = 1'b0;
      exp_rd.delete();
      exp_wr.delete();
      done_seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (done || busy) done_seen++;
      end
      chk("abort_no_done", done_seen, 0);
      cmp_mem("abort_mem");

      // Random jobs, overlap allowed
      for (int j = 0; j < 10; j++)
         run_job(4'($urandom_range(0, 4)), 12'($urandom), 12'($urandom),
                 12'($urandom), $urandom_range(1, 12), 1'b0);

      // Maximum element count
      run_job(ALU_XOR, 12'h800, 12'h900, 12'hB00, 255, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_alu_engine.md
Name: mem_alu_engine

Overview:
Parametrised vector compute engine. It sits between the memory and the ALU in the top-level integration. On a start command it reads operand pairs from two memory regions, passes each pair through the combinational ALU, and writes the results to a destination region. The job repeats for a programmable element count. This replaces testbench-driven manual sequencing of the memory and ALU.

Parameters:
DATA_W, 8, width of memory words and ALU operands.
ADDR_W, 12, memory address width.
OP_W, 4, ALU opcode width.
LEN_W, 8, width of the element-count field.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle job request; accepted only in IDLE.
opcode  input  OP_W  ALU operation for the job; latched at start.
src_a  input  ADDR_W  base address of operand A vector; latched at start.
src_b  input  ADDR_W  base address of operand B vector; latched at start.
dst  input  ADDR_W  base address of result vector; latched at start.
count  input  LEN_W  number of elements; latched at start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the job completes.
carry_any  output  1  sticky OR of alu_carry over the job; cleared at start.
mem_we  output  1  memory write enable.
mem_re  output  1  memory read enable.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  DATA_W  memory write data.
mem_rdata  input  DATA_W  memory read data; valid the cycle after mem_re.
alu_a  output  DATA_W  ALU operand A (registered).
alu_b  output  DATA_W  ALU operand B (registered).
alu_op  output  OP_W  ALU opcode (registered).
alu_result  input  DATA_W  combinational ALU result.
alu_carry  input  1  combinational ALU carry.

Behaviour:
- Reset values: busy=0, done=0, carry_any=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, alu_a=0, alu_b=0, alu_op=0. FSM goes to IDLE.
- Reset is synchronous. An asserted reset mid-job aborts on that edge: no further memory writes, and done is not pulsed.
- States: IDLE, RD_A, RD_B, EXEC, WR, FIN.
- IDLE: on start=1, latch the inputs, clear carry_any and the element index i.
  - count=0 goes to FIN.
  - Otherwise go to RD_A.
- RD_A: mem_re=1, mem_addr=src_a+i. Next state RD_B.
- RD_B: capture mem_rdata into alu_a. mem_re=1, mem_addr=src_b+i. Next state EXEC.
- EXEC: capture mem_rdata into alu_b; alu_op=opcode. Next state WR.
- WR: mem_we=1, mem_addr=dst+i, mem_wdata=alu_result. carry_any |= alu_carry. Increment i.
  - If i+1==count, go to FIN.
  - Otherwise go to RD_A.
- FIN: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Throughput: 4 cycles per element. Job latency from start edge to the done pulse is 4*count+2 cycles (count=0 gives 2).
- mem_we and mem_re are never high in the same cycle. Both are 0 in IDLE and FIN.
- Address arithmetic is modulo 2^ADDR_W; a region crossing the top of memory wraps to 0.
- Overlapping regions are legal. Element i's write occurs after element i's reads, so dst==src_a performs an in-place update.
- start while busy is ignored; the latched job parameters do not change.
- start asserted in the same cycle as reset: reset wins.
- The count maximum 2^LEN_W-1 is supported. The index register is LEN_W bits and never overflows before termination.

Decomposition:
- Shared package mem_alu_pkg:
  - state enum encoding (IDLE..FIN);
  - DATA_W/ADDR_W/OP_W defaults;
  - ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ...) shared with the alu module.
- One natural sub-module: mem_alu_addr_gen. It holds the latched bases and the index counter, and produces the src_a+i, src_b+i and dst+i addresses plus the last-element flag.
- FSM and datapath registers stay in mem_alu_engine.

Test Plan:
1. Preload mem[0x010..0x013]={1,2,3,4} and mem[0x020..0x023]={10,20,30,40}. Start with src_a=0x010, src_b=0x020, dst=0x030, count=4, opcode=ALU_ADD.
   -> mem[0x030..0x033]={11,22,33,44}, done pulses at cycle 18 after start, carry_any=0.
2. Preload A=0xFF, B=0x01. Run count=1 with ALU_ADD.
   -> result 0x00, carry_any=1. A second job with 0x01+0x01 -> carry_any cleared to 0 at start and stays 0.
3. Start with count=0.
   -> done pulses 2 cycles later, mem_we/mem_re never asserted, memory unchanged.
4. Run src_a=0xFFE, src_b=0x100, dst=0xFFF, count=3.
   -> reads at 0xFFE, 0xFFF, 0x000; writes at 0xFFF, 0x000, 0x001 (wrap). The in-place overlap yields values consistent with the read-before-write order.
5. Issue a second start with different params 5 cycles into a count=4 job.
   -> ignored; the original job completes unchanged and busy stays high throughout.
6. Assert reset for one cycle during the WR of element 2 of a count=4 job.
   -> that write does not occur, elements 2 and 3 are unwritten, done never pulses, outputs hold reset values, and a following job runs correctly.
